// File: rtl/rr_arb32.sv
// ---------------------------------------------------------------------------
// rr_arb32 : 32-requester round-robin arbiter with a registered, handshaked
//            grant, shared among up to 32 out-of-order core entries.
//
// Ports
//   clk        in   1   core clock, all state updates on the rising edge
//   rst        in   1   synchronous, active-high reset
//   lock       in   1   (only with RR_ARB32_LOCK_EN) hold the current
//                       requester across an accept for multi-beat transfers
//   req        in  32   request lines, bit i = requester i
//   gnt_ready  in   1   downstream accepts the presented grant this cycle
//   gnt_valid  out  1   a grant is registered and presented
//   gnt_oh     out 32   one-hot grant vector, zero when gnt_valid=0
//   gnt_idx    out  5   binary index of the granted requester, 0 when idle
//   any_req    out  1   combinational OR of req (or32 instance)
//
// Optional feature macro: RR_ARB32_LOCK_EN (adds the lock input).
//
// The two FSM states map directly onto gnt_valid: IDLE presents nothing,
// HOLD presents a bit-stable grant until gnt_ready accepts it.
// ---------------------------------------------------------------------------

// Reduction OR used for the any-request detect.
module or32 (
    input  logic [31:0] a,
    output logic        y
);
    assign y = |a;
endmodule

module rr_arb32 (
    input  logic        clk,
    input  logic        rst,
`ifdef RR_ARB32_LOCK_EN
    input  logic        lock,
`endif
    input  logic [31:0] req,
    input  logic        gnt_ready,
    output logic        gnt_valid,
    output logic [31:0] gnt_oh,
    output logic [4:0]  gnt_idx,
    output logic        any_req
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [31:0] gnt_oh_q, gnt_oh_d;
    logic [4:0]  gnt_idx_q, gnt_idx_d;
    logic        accept;
    logic        keep_lock;
    logic [4:0]  next_ptr;

    or32 u_or32 (
        .a (req),
        .y (any_req)
    );

    // First set bit of r scanning circularly upward from position p.
    // The 5-bit index addition wraps 31 -> 0 on its own.
    function automatic logic [4:0] pick(input logic [31:0] r, input logic [4:0] p);
        logic [4:0] res;
        logic [4:0] j;
        logic       found;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < 32; k++) begin
            j = p + 5'(k);
            if (!found && r[j]) begin
                res   = j;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign accept   = (state_q == HOLD) && gnt_ready;
    assign next_ptr = gnt_idx_q + 5'd1;

`ifdef RR_ARB32_LOCK_EN
    // Lock only matters on an accept, and only while the owner still requests.
    assign keep_lock = lock && req[gnt_idx_q];
`else
    assign keep_lock = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_oh_d  = gnt_oh_q;
        gnt_idx_d = gnt_idx_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_idx_d = pick(req, ptr_q);
                    gnt_oh_d  = 32'd1 << gnt_idx_d;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                // Without an accept the grant is frozen regardless of req.
                if (accept) begin
                    if (keep_lock) begin
                        // Same requester again, pointer untouched.
                        gnt_idx_d = gnt_idx_q;
                        gnt_oh_d  = gnt_oh_q;
                    end else begin
                        // Accepted requester becomes lowest priority.
                        ptr_d = next_ptr;
                        if (any_req) begin
                            gnt_idx_d = pick(req, next_ptr);
                            gnt_oh_d  = 32'd1 << gnt_idx_d;
                        end else begin
                            gnt_idx_d = '0;
                            gnt_oh_d  = '0;
                            state_d   = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_idx_d = '0;
                gnt_oh_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_oh_q  <= '0;
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_oh_q  <= gnt_oh_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    assign gnt_valid = (state_q == HOLD);
    assign gnt_oh    = gnt_oh_q;
    assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_rr_arb32.sv
module tb_rr_arb32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req;
    logic        gnt_ready;
    logic        gnt_valid;
    logic [31:0] gnt_oh;
    logic [4:0]  gnt_idx;
    logic        any_req;
`ifdef RR_ARB32_LOCK_EN
    logic        lock;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_arb32 dut (
        .clk       (clk),
        .rst       (rst),
`ifdef RR_ARB32_LOCK_EN
        .lock      (lock),
`endif
        .req       (req),
        .gnt_ready (gnt_ready),
        .gnt_valid (gnt_valid),
        .gnt_oh    (gnt_oh),
        .gnt_idx   (gnt_idx),
        .any_req   (any_req)
    );

    typedef struct {
        logic [31:0] req;
        logic        rdy;
        logic        exp_v;
        logic [4:0]  exp_idx;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_grant(input string nm, input logic ev, input logic [4:0] eidx);
        logic [31:0] eoh;
        eoh = ev ? (32'd1 << eidx) : 32'd0;
        chk({nm, ".valid"}, {31'd0, gnt_valid}, {31'd0, ev});
        chk({nm, ".idx"}, {27'd0, gnt_idx}, ev ? {27'd0, eidx} : 32'd0);
        chk({nm, ".oh"}, gnt_oh, eoh);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        gnt_ready = 1'b0;
`ifdef RR_ARB32_LOCK_EN
        lock      = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Directed table starting from reset (ptr=0, idle).
        tbl[0] = '{32'h0000_0001, 1'b1, 1'b1, 5'd0};  // idle load
        tbl[1] = '{32'h0000_0001, 1'b1, 1'b1, 5'd0};  // sole requester re-granted
        tbl[2] = '{32'h0000_0000, 1'b1, 1'b0, 5'd0};  // accept, ptr=1, go idle
        tbl[3] = '{32'h0000_0030, 1'b0, 1'b1, 5'd4};  // pick from 1 -> 4
        tbl[4] = '{32'h0000_0030, 1'b1, 1'b1, 5'd5};  // accept 4, pick from 5
        tbl[5] = '{32'h0000_0030, 1'b1, 1'b1, 5'd4};  // accept 5, wrap to 4
        tbl[6] = '{32'h0000_0000, 1'b0, 1'b1, 5'd4};  // held, req withdrawn
        tbl[7] = '{32'h0000_0000, 1'b1, 1'b0, 5'd0};  // accept, idle
        tbl[8] = '{32'h0000_0000, 1'b1, 1'b0, 5'd0};  // ready ignored in idle

        do_reset();
        chk_grant("reset", 1'b0, 5'd0);
        chk("reset.ptr", {27'd0, dut.ptr_q}, 32'd0);
        chk("reset.any_req", {31'd0, any_req}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            req       = tbl[i].req;
            gnt_ready = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d.any_req", i), {31'd0, any_req}, {31'd0, (tbl[i].req != 0)});
            step();
            chk_grant($sformatf("tbl%0d", i), tbl[i].exp_v, tbl[i].exp_idx);
            if (i == 2) chk("tbl2.ptr", {27'd0, dut.ptr_q}, 32'd1);
        end

        // All requesters, continuous accept: 0..31 then 0, no bubbles.
        do_reset();
        req       = 32'hFFFF_FFFF;
        gnt_ready = 1'b1;
        for (int k = 0; k < 33; k++) begin
            step();
            chk_grant($sformatf("all.%0d", k), 1'b1, 5'(k % 32));
        end

        // Wrap-around with ptr parked at 31.
        do_reset();
        req       = 32'h4000_0000;
        gnt_ready = 1'b0;
        step();
        chk_grant("wrap.g30", 1'b1, 5'd30);
        req       = 32'h0;
        gnt_ready = 1'b1;
        step();
        chk_grant("wrap.idle", 1'b0, 5'd0);
        chk("wrap.ptr", {27'd0, dut.ptr_q}, 32'd31);
        req = 32'h8000_0001;
        step();
        chk_grant("wrap.a", 1'b1, 5'd31);
        step();
        chk_grant("wrap.b", 1'b1, 5'd0);
        step();
        chk_grant("wrap.c", 1'b1, 5'd31);

        // Held grant ignores request changes while not ready.
        do_reset();
        req       = 32'h0000_0020;
        gnt_ready = 1'b0;
        step();
        chk_grant("hold.g5", 1'b1, 5'd5);
        req = 32'h0000_0100;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_grant($sformatf("hold.%0d", k), 1'b1, 5'd5);
        end
        gnt_ready = 1'b1;
        step();
        chk_grant("hold.next", 1'b1, 5'd8);

        // Reset in the middle of a held grant.
        do_reset();
        req       = 32'h0000_1000;
        gnt_ready = 1'b0;
        step();
        chk_grant("rsthold.g12", 1'b1, 5'd12);
        rst = 1'b1;
        step();
        chk_grant("rsthold.drop", 1'b0, 5'd0);
        chk("rsthold.ptr", {27'd0, dut.ptr_q}, 32'd0);
        rst = 1'b0;
        req = 32'h0000_1001;
        step();
        chk_grant("rsthold.after", 1'b1, 5'd0);

`ifdef RR_ARB32_LOCK_EN
        // Locked multi-beat: 1,1,1,1 then 2 once lock drops.
        do_reset();
        req       = 32'h0000_0006;
        gnt_ready = 1'b1;
        lock      = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_grant($sformatf("lock.%0d", k), 1'b1, 5'd1);
        end
        lock = 1'b0;
        step();
        chk_grant("lock.rel", 1'b1, 5'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rr_arb32.md
# rr_arb32

32-requester round-robin arbiter with a registered, handshaked grant. It shares one downstream resource (issue port, writeback bus, cache fill port) among up to 32 out-of-order core entries. An `or32` reduction tree provides the any-request detect. One grant is issued per accepted handshake, and fairness is guaranteed by a rotating priority pointer.

## Interface
Parameters:
- none; requester count is fixed at 32.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  32  per-requester request lines; bit i = requester i.
- `gnt_ready`  in  1  downstream accepts the current grant this cycle.
- `gnt_valid`  out  1  grant registered and presented.
- `gnt_oh`  out  32  one-hot grant vector; all zeros when `gnt_valid`=0.
- `gnt_idx`  out  5  binary index of the granted requester; 0 when `gnt_valid`=0.
- `any_req`  out  1  combinational OR of `req`, from an `or32` instance.

## Operation
- State: 5-bit priority pointer `ptr`, plus the grant register (`gnt_valid`, `gnt_oh`, `gnt_idx`).
- Two states, encoded by `gnt_valid`:
  - IDLE: `gnt_valid`=0.
  - HOLD: `gnt_valid`=1.
- Pick function: the first set bit of `req` scanning circularly from position p upward (p, p+1, …, 31, 0, …, p−1).
- IDLE:
  - If `any_req`=1, load the grant with pick(`ptr`) and go to HOLD.
  - Otherwise stay in IDLE; outputs stay zero.
- HOLD with `gnt_ready`=0:
  - Grant is held bit-stable.
  - `req` changes are ignored, including withdrawal of the granted requester.
  - `ptr` is unchanged.
- HOLD with `gnt_ready`=1 (accept):
  - `ptr` <= `gnt_idx`+1 mod 32 (31 wraps to 0).
  - If `any_req`=1 in the same cycle, load the grant with pick(`gnt_idx`+1 mod 32) and stay in HOLD. This allows back-to-back grants.
  - Otherwise go to IDLE.
- The requester just accepted is lowest priority for the next pick. It is re-granted only if it is the sole requester.
- `gnt_ready` is ignored in IDLE.
- Invariants:
  - `gnt_oh` has exactly one bit set when `gnt_valid`=1.
  - `gnt_oh[gnt_idx]`=1 whenever `gnt_valid`=1.
  - Grant outputs are zero when `gnt_valid`=0.
- Reset: `ptr`=0, `gnt_valid`=0, `gnt_oh`=0, `gnt_idx`=0. Reset asserted mid-HOLD drops the grant on the next edge with no accept recorded.

## Timing
- Request-to-grant latency: 1 cycle. A `req` sampled at edge N gives a grant visible after edge N.
- Throughput: 1 grant per cycle while `gnt_ready`=1 and requests persist.
- Grant outputs are registered. `any_req` is the only combinational output, and the only combinational path is `req`→`any_req`.
- Fairness: a continuously requesting requester is granted within 32 accepted grants.

## Configuration
- `RR_ARB32_LOCK_EN` defined:
  - Adds input port `lock` (1 bit).
  - On accept with `lock`=1 and `req[gnt_idx]`=1, the same requester is re-granted next cycle and `ptr` is not advanced. This supports multi-beat transactions.
  - If `lock`=1 but `req[gnt_idx]`=0, normal round-robin applies.
  - `lock` is ignored when there is no accept.
- Undefined: port `lock` is absent and the pointer always advances on accept.

## Test plan
- Reset, then `req`=0x0000_0001 with `gnt_ready`=1 held:
  - `gnt_valid`=1 and `gnt_idx`=0 one cycle after `req`.
  - `ptr` becomes 1 after the accept.
- `req`=0xFFFF_FFFF and `gnt_ready`=1 for 33 cycles:
  - `gnt_idx` sequence is 0,1,…,31,0.
  - `gnt_valid` stays high throughout with no bubbles.
- `req`=0x8000_0001 with `ptr`=31:
  - First grant goes to 31, then 0, then 31 (wrap-around).
- Grant to 5 held with `gnt_ready`=0 for 4 cycles while `req` changes to 0x0000_0100:
  - `gnt_oh`=0x0000_0020 stays stable.
  - On accept, the next grant is idx 8.
- Reset asserted mid-HOLD (grant idx 12):
  - The next cycle shows all outputs 0 and `ptr`=0.
  - `req`=0x0000_1001 afterward grants idx 0.
- With `RR_ARB32_LOCK_EN`: `req`=0x0000_0006, `lock`=1 for 3 accepts, then 0:
  - Grants are 1,1,1,1, then 2.
